// File: rtl/jtag_idcode_reader.sv
// JTAG host that walks a TAP through Test-Logic-Reset into Shift-DR, reads the
// DR_LEN-bit IDCODE LSB first, and then parks the TAP in Run-Test/Idle.
module jtag_idcode_reader #(
    parameter int                CLK_DIV     = 1,
    parameter int                DR_LEN      = 32,
    parameter logic [DR_LEN-1:0] EXPECTED_ID = 32'h1000_1003
) (
    input  logic              CLK,
    input  logic              TRST,
    input  logic              start,
    input  logic              TDO_I,
    output logic              TCK_O,
    output logic              TMS_O,
    output logic              TDI_O,
    output logic              busy,
    output logic              done,
    output logic [DR_LEN-1:0] idcode,
    output logic              id_valid,
    output logic              id_match
);

    typedef enum logic [3:0] {
        S_IDLE, S_RESET, S_GO_IDLE, S_SEL_DR, S_CAPTURE,
        S_ENTER_SH, S_SHIFT, S_UPDATE, S_RETURN, S_DONE
    } state_t;

    localparam int                DIV_W      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0]  DIV_LAST   = DIV_W'(CLK_DIV - 1);
    localparam int                CNT_W      = (DR_LEN > 8) ? $clog2(DR_LEN) : 3;
    localparam logic [CNT_W-1:0]  RESET_LAST = CNT_W'(4);
    localparam logic [CNT_W-1:0]  SHIFT_LAST = CNT_W'(DR_LEN - 1);

    state_t             state;
    state_t             state_nx;
    logic [DIV_W-1:0]   div_cnt;
    logic [CNT_W-1:0]   bit_cnt;
    logic [DR_LEN-1:0]  shreg;
    logic               accept;
    logic               tick;
    logic               rise;
    logic               fall;
    logic               tms_nx;
    logic               done_nx;

    // A captured value of all-zeros or all-ones means no TAP is driving TDO.
    function automatic logic valid_id(input logic [DR_LEN-1:0] v);
        return v[0] && (v != '1) && (v != '0);
    endfunction

    // A start coinciding with the done pulse is dropped on purpose.
    assign accept = start && !busy && !done;
    assign tick   = busy && (div_cnt == DIV_LAST);
    assign rise   = tick && !TCK_O;
    assign fall   = tick && TCK_O;
    assign TDI_O  = 1'b0;

    always_ff @(posedge CLK or negedge TRST) begin
        if (!TRST) state <= S_IDLE;
        else       state <= state_nx;
    end

    // The FSM advances on TCK rises; the state then names the next rise's TMS.
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:     if (accept) state_nx = S_RESET;
            S_RESET:    if (rise && bit_cnt == RESET_LAST) state_nx = S_GO_IDLE;
            S_GO_IDLE:  if (rise) state_nx = S_SEL_DR;
            S_SEL_DR:   if (rise) state_nx = S_CAPTURE;
            S_CAPTURE:  if (rise) state_nx = S_ENTER_SH;
            S_ENTER_SH: if (rise) state_nx = S_SHIFT;
            S_SHIFT:    if (rise && bit_cnt == SHIFT_LAST) state_nx = S_UPDATE;
            S_UPDATE:   if (rise) state_nx = S_RETURN;
            S_RETURN:   if (rise) state_nx = S_DONE;
            S_DONE:     if (fall) state_nx = S_IDLE;
            default:    state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        tms_nx  = TMS_O;
        done_nx = (state == S_DONE) && fall;
        case (state)
            S_RESET:    tms_nx = 1'b1;
            S_GO_IDLE:  tms_nx = 1'b0;
            S_SEL_DR:   tms_nx = 1'b1;
            S_CAPTURE:  tms_nx = 1'b0;
            S_ENTER_SH: tms_nx = 1'b0;
            S_SHIFT:    tms_nx = (bit_cnt == SHIFT_LAST);
            S_UPDATE:   tms_nx = 1'b1;
            S_RETURN:   tms_nx = 1'b0;
            S_DONE:     tms_nx = 1'b0;
            default:    tms_nx = TMS_O;
        endcase
    end

    always_ff @(posedge CLK or negedge TRST) begin
        if (!TRST) begin
            TCK_O    <= 1'b0;
            TMS_O    <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
            idcode   <= '0;
            id_valid <= 1'b0;
            id_match <= 1'b0;
            div_cnt  <= '0;
            bit_cnt  <= '0;
        end else begin
            done <= done_nx;
            if (accept) begin
                busy    <= 1'b1;
                TCK_O   <= 1'b0;
                TMS_O   <= 1'b1;
                div_cnt <= '0;
                bit_cnt <= '0;
            end else if (busy) begin
                div_cnt <= tick ? '0 : div_cnt + 1'b1;
                if (tick) TCK_O <= ~TCK_O;
                if (fall) TMS_O <= tms_nx;
                if (rise && state == S_RESET)
                    bit_cnt <= (bit_cnt == RESET_LAST) ? '0 : bit_cnt + 1'b1;
                if (rise && state == S_SHIFT && bit_cnt != SHIFT_LAST)
                    bit_cnt <= bit_cnt + 1'b1;
                if (done_nx) begin
                    busy     <= 1'b0;
                    idcode   <= shreg;
                    id_valid <= valid_id(shreg);
                    id_match <= valid_id(shreg) && (shreg == EXPECTED_ID);
                end
            end
        end
    end

    // TDO is taken on the CLK edge that raises TCK, before the TAP reacts.
    always_ff @(posedge CLK) begin
        if (rise && state == S_SHIFT) shreg <= {TDO_I, shreg[DR_LEN-1:1]};
    end

endmodule

// File: tb/tb_jtag_idcode_reader.sv
// Bench for jtag_idcode_reader: two instances (CLK_DIV 1 and 3), each talking to
// a behavioural IEEE 1149.1 TAP model, with randomized IDCODE reads.
module tb_jtag_idcode_reader;

    localparam int NX0[16] = '{1, 1, 3, 4, 4, 6, 6, 4, 1, 10, 11, 11, 13, 13, 11, 1};
    localparam int NX1[16] = '{0, 2, 9, 5, 5, 8, 7, 8, 2, 0, 12, 12, 15, 14, 15, 2};
    localparam int ST_CAPDR = 3;
    localparam int ST_SHDR  = 4;
    localparam int ST_RTI   = 1;

    logic        CLK = 1'b0;
    logic        TRST = 1'b0;
    logic        start [2] = '{1'b0, 1'b0};
    logic        tdo   [2];
    logic        tck   [2];
    logic        tms   [2];
    logic        tdi   [2];
    logic        busy  [2];
    logic        done  [2];
    logic [31:0] idc   [2];
    logic        vld   [2];
    logic        mtc   [2];

    int          checks = 0;
    int          errors = 0;
    int          edge_no = 0;

    int          tdo_mode [2] = '{0, 0};
    logic [31:0] tap_id   [2] = '{32'h0, 32'h0};
    int          tap_st   [2] = '{6, 13};
    logic [31:0] tap_dr   [2] = '{32'h0, 32'h0};

    int          e0        [2] = '{0, 0};
    int          rise_n    [2] = '{0, 0};
    int          bad_rise  [2] = '{0, 0};
    int          glitch    [2] = '{0, 0};
    int          tdi_bad   [2] = '{0, 0};
    int          done_total[2] = '{0, 0};
    logic [63:0] tms_log   [2] = '{64'h0, 64'h0};
    logic        tck_q     [2] = '{1'b0, 1'b0};
    logic        tms_q     [2] = '{1'b1, 1'b1};
    logic        busy_q    [2] = '{1'b0, 1'b0};
    logic        trst_q = 1'b0;

    always #5 CLK = ~CLK;

    jtag_idcode_reader #(.CLK_DIV(1)) u_div1 (
        .CLK(CLK), .TRST(TRST), .start(start[0]), .TDO_I(tdo[0]),
        .TCK_O(tck[0]), .TMS_O(tms[0]), .TDI_O(tdi[0]), .busy(busy[0]),
        .done(done[0]), .idcode(idc[0]), .id_valid(vld[0]), .id_match(mtc[0])
    );

    jtag_idcode_reader #(.CLK_DIV(3)) u_div3 (
        .CLK(CLK), .TRST(TRST), .start(start[1]), .TDO_I(tdo[1]),
        .TCK_O(tck[1]), .TMS_O(tms[1]), .TDI_O(tdi[1]), .busy(busy[1]),
        .done(done[1]), .idcode(idc[1]), .id_valid(vld[1]), .id_match(mtc[1])
    );

    function automatic int div_of(input int i);
        return (i == 0) ? 1 : 3;
    endfunction

    // TMS seen by the TAP at each rise: TLR x5, RTI, Sel-DR, Capture, Shift, shift x31, Exit1, Update, RTI.
    function automatic logic [63:0] exp_tms();
        int          reps [9] = '{5, 1, 1, 1, 1, 31, 1, 1, 1};
        logic        bits [9] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        logic [63:0] v = '0;
        for (int s = 0; s < 9; s++)
            for (int r = 0; r < reps[s]; r++) v = {v[62:0], bits[s]};
        return v;
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            if (tdo_mode[i] == 1)      tdo[i] = 1'b1;
            else if (tdo_mode[i] == 2) tdo[i] = 1'b0;
            else                       tdo[i] = (tap_st[i] == ST_SHDR) ? tap_dr[i][0] : 1'b0;
        end
    end

    always @(posedge CLK) edge_no <= edge_no + 1;

    // TAP model and protocol monitor, evaluated on the falling CLK edge.
    always @(negedge CLK) begin
        for (int i = 0; i < 2; i++) begin
            if (busy[i] && !busy_q[i]) begin
                e0[i]       <= edge_no;
                rise_n[i]   <= 0;
                bad_rise[i] <= 0;
                glitch[i]   <= 0;
                tms_log[i]  <= '0;
            end else if (tck[i] && !tck_q[i]) begin
                rise_n[i] <= rise_n[i] + 1;
                if (edge_no != e0[i] + (2 * (rise_n[i] + 1) - 1) * div_of(i))
                    bad_rise[i] <= bad_rise[i] + 1;
                tms_log[i] <= {tms_log[i][62:0], tms[i]};
                if (tap_st[i] == ST_CAPDR)     tap_dr[i] <= tap_id[i];
                else if (tap_st[i] == ST_SHDR) tap_dr[i] <= {tdi[i], tap_dr[i][31:1]};
                tap_st[i] <= tms[i] ? NX1[tap_st[i]] : NX0[tap_st[i]];
            end
            if (TRST && trst_q && tms[i] != tms_q[i] && !(tck_q[i] && !tck[i]) && !(busy[i] && !busy_q[i]))
                glitch[i] <= glitch[i] + 1;
            if (tdi[i]) tdi_bad[i] <= tdi_bad[i] + 1;
            if (done[i]) done_total[i] <= done_total[i] + 1;
            tck_q[i]  <= tck[i];
            tms_q[i]  <= tms[i];
            busy_q[i] <= busy[i];
        end
        trst_q <= TRST;
    end

    task automatic chk_reset(input int i, input string nm);
        chk({nm, ":rst_tck"}, tck[i], 0);
        chk({nm, ":rst_tms"}, tms[i], 1);
        chk({nm, ":rst_tdi"}, tdi[i], 0);
        chk({nm, ":rst_busy"}, busy[i], 0);
        chk({nm, ":rst_done"}, done[i], 0);
        chk({nm, ":rst_idcode"}, idc[i], 0);
        chk({nm, ":rst_valid"}, vld[i], 0);
        chk({nm, ":rst_match"}, mtc[i], 0);
    endtask

    // mode 0: TAP model, 1: TDO tied high, 2: TDO tied low
    task automatic run_read(input int i, input int mode, input logic [31:0] id, input int poke_at,
                            input int abort_at, input bit start_on_done, input string nm);
        int          div = div_of(i);
        int          dn0 = done_total[i];
        int          kd  = -1;
        bit          seen = 0;
        logic [31:0] e_id;
        bit          e_valid;
        tdo_mode[i] = mode;
        tap_id[i]   = id;
        e_id    = (mode == 1) ? 32'hFFFF_FFFF : (mode == 2) ? 32'h0 : id;
        e_valid = e_id[0] && (e_id != 32'hFFFF_FFFF) && (e_id != 32'h0);
        @(negedge CLK) start[i] = 1'b1;
        @(negedge CLK) start[i] = 1'b0;
        chk({nm, ":busy_on_accept"}, busy[i], 1);
        for (int k = 1; k <= 86 * div + 20 && !seen; k++) begin
            @(negedge CLK);
            start[i] = 1'b0;
            if (k == poke_at) start[i] = 1'b1;
            if (k == abort_at) begin
                TRST = 1'b0;
                #1;
                chk_reset(i, {nm, ":abort"});
                repeat (4) @(negedge CLK);
                chk({nm, ":abort_no_done"}, done_total[i] - dn0, 0);
                chk({nm, ":abort_busy"}, busy[i], 0);
                return;
            end
            if (done[i]) begin
                seen = 1;
                kd   = k;
            end
        end
        chk({nm, ":done_seen"}, seen, 1);
        chk({nm, ":done_latency"}, kd, 86 * div);
        chk({nm, ":busy_at_done"}, busy[i], 0);
        chk({nm, ":idcode"}, idc[i], e_id);
        chk({nm, ":id_valid"}, vld[i], e_valid);
        chk({nm, ":id_match"}, mtc[i], e_valid && (e_id == 32'h1000_1003));
        chk({nm, ":rises"}, rise_n[i], 43);
        chk({nm, ":tms_seq"}, tms_log[i] & 64'h7FF_FFFF_FFFF, exp_tms());
        chk({nm, ":rise_timing"}, bad_rise[i], 0);
        chk({nm, ":tms_change"}, glitch[i], 0);
        chk({nm, ":tap_in_rti"}, tap_st[i], ST_RTI);
        chk({nm, ":tdi_low"}, tdi_bad[i], 0);
        if (start_on_done) start[i] = 1'b1;
        @(negedge CLK) start[i] = 1'b0;
        chk({nm, ":done_one_cycle"}, done[i], 0);
        chk({nm, ":idle_busy"}, busy[i], 0);
        chk({nm, ":idle_tck"}, tck[i], 0);
        chk({nm, ":idle_tms"}, tms[i], 0);
        repeat (3) @(negedge CLK);
        chk({nm, ":done_count"}, done_total[i] - dn0, 1);
        chk({nm, ":still_idle"}, busy[i], 0);
    endtask

    initial begin
        logic [31:0] rid;
        repeat (3) @(negedge CLK);
        chk_reset(0, "init0");
        chk_reset(1, "init1");
        @(negedge CLK) TRST = 1'b1;

        run_read(0, 0, 32'h1000_1003, 0, 0, 0, "div1_match");
        run_read(1, 0, 32'h1000_1003, 0, 0, 0, "div3_match");
        run_read(0, 1, 32'h0, 0, 0, 0, "tdo_high");
        run_read(0, 2, 32'h0, 0, 0, 0, "tdo_low");
        run_read(0, 0, 32'h2000_1003, 0, 0, 0, "other_id");
        run_read(0, 0, 32'h1000_1003, 20, 0, 0, "start_while_busy");
        run_read(0, 0, 32'h1000_1003, 0, 0, 1, "start_on_done");

        run_read(0, 0, 32'h1000_1003, 0, 40, 0, "abort");
        @(negedge CLK) TRST = 1'b1;
        run_read(0, 0, 32'h1000_1003, 0, 0, 0, "after_abort");

        for (int r = 0; r < 8; r++) begin
            rid = $urandom;
            if (r % 2 == 0) rid[0] = 1'b1;
            repeat ($urandom_range(0, 5)) @(negedge CLK);
            run_read((r % 4 == 3) ? 1 : 0, 0, rid, 0, 0, 0, $sformatf("rand%0d", r));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
